// File: rtl/rds_msg_dbuf_pkg.sv
// Shared types and constants for the double-buffered RDS message store.
// The default message image and the read-FSM state encoding live here.
package rds_msg_dbuf_pkg;

  localparam int RDS_MSG_BYTES = 52;
  localparam int RDS_WORD_W    = 8;

  typedef logic [RDS_WORD_W-1:0] rds_word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    SHOW  = 2'd2
  } rd_state_e;

  // Power-up message image loaded into both banks.
  localparam rds_word_t rds_msg_map [RDS_MSG_BYTES] = '{
    "H", "E", "L", "L", "O", " ", "R", "D", "S", " ", "W", "O", "R",
    "L", "D", " ", "F", "R", "O", "M", " ", "D", "B", "U", "F", " ",
    "M", "E", "S", "S", "A", "G", "E", " ", "S", "T", "O", "R", "E",
    " ", "0", "1", "2", "3", "4", "5", "6", "7", "8", "9", "A", "B"
  };

endpackage

// File: rtl/rds_dpram.sv
// Two-bank message RAM: one write port, one read port for the streamer and,
// when RDS_SHADOW_READBACK_EN is defined, a second read port for readback.
// Address is {bank, word}; both banks power up holding rds_msg_map.
module rds_dpram
  import rds_msg_dbuf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MSG_BYTES = RDS_MSG_BYTES,
  parameter int ADDR_W    = $clog2(MSG_BYTES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W:0]   i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_rb_bank,
  input  logic [ADDR_W-1:0] i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data
);

  localparam int BANK_WORDS = 1 << ADDR_W;
  localparam int DEPTH      = 2 * BANK_WORDS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_BYTES - 1);

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    m = '0;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < MSG_BYTES; a++) begin
        if (a < RDS_MSG_BYTES) m[b*BANK_WORDS+a] = DATA_W'(rds_msg_map[a]);
      end
    end
    return m;
  endfunction

  mem_t              r_mem = init_mem();
  logic [DATA_W-1:0] r_rdata;

  // Write port plus registered streamer read port (block-RAM style, no reset).
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

`ifdef RDS_SHADOW_READBACK_EN
  logic [DATA_W-1:0] r_rb_data;

  // Registered shadow readback; out-of-range addresses read as zero.
  always_ff @(posedge i_clk) begin
    if (i_rst)                       r_rb_data <= '0;
    else if (i_rb_addr <= LAST_ADDR) r_rb_data <= r_mem[{i_rb_bank, i_rb_addr}];
    else                             r_rb_data <= '0;
  end

  assign o_rb_data = r_rb_data;
`else
  logic w_unused_rb;
  assign w_unused_rb = ^{i_rst, i_rb_bank, i_rb_addr, LAST_ADDR};
  assign o_rb_data   = '0;
`endif

endmodule

// File: rtl/rds_msg_dbuf.sv
// Double-buffered RDS message store. The active bank streams cyclically to
// the group encoder over valid/ready; the CPU fills the shadow bank and
// commits, and the banks swap only on the last-word handshake.
// Optional shadow readback port: define RDS_SHADOW_READBACK_EN.
module rds_msg_dbuf
  import rds_msg_dbuf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MSG_BYTES = RDS_MSG_BYTES,
  parameter int ADDR_W    = $clog2(MSG_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  output logic              commit_pending,
  output logic              active_bank,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              msg_wrap,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_BYTES - 1);

  rd_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_bank, r_pending;
  logic              w_hs, w_wrap, w_swap, w_wr_ok;
  logic [DATA_W-1:0] w_ram_q;

  assign w_hs   = rd_valid && rd_ready;
  assign w_wrap = w_hs && (r_ptr == LAST_ADDR);
  assign w_swap = w_wrap && (r_pending || commit);
  // Shadow is frozen from the commit cycle until the swap.
  assign w_wr_ok = wr_en && (wr_addr <= LAST_ADDR) && !r_pending && !commit;

  rds_dpram #(
    .DATA_W   (DATA_W),
    .MSG_BYTES(MSG_BYTES),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_we     (w_wr_ok),
    .i_waddr  ({~r_bank, wr_addr}),
    .i_wdata  (wr_data),
    .i_raddr  ({r_bank, r_ptr}),
    .o_rdata  (w_ram_q),
    .i_rb_bank(~r_bank),
    .i_rb_addr(rb_addr),
    .o_rb_data(rb_data)
  );

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // Read FSM next state: FETCH -> LOAD -> SHOW, leave SHOW on handshake.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FETCH:   w_state_nxt = LOAD;
      LOAD:    w_state_nxt = SHOW;
      SHOW:    if (rd_ready) w_state_nxt = FETCH;
      default: w_state_nxt = FETCH;
    endcase
  end

  // Word pointer, bank select and commit bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_bank    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_hs) r_ptr <= w_wrap ? '0 : r_ptr + 1'b1;
      if (w_swap) begin
        r_bank    <= ~r_bank;
        r_pending <= 1'b0;
      end else if (commit) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Output word register: loaded in LOAD, held through SHOW.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
    end else if (r_state == LOAD) begin
      rd_valid <= 1'b1;
      rd_data  <= w_ram_q;
      rd_addr  <= r_ptr;
    end else if (w_hs) begin
      rd_valid <= 1'b0;
    end
  end

  assign msg_wrap       = w_wrap && !rst;
  assign active_bank    = r_bank;
  assign commit_pending = r_pending;

endmodule

// File: tb/tb_rds_msg_dbuf.sv
// Bench for rds_msg_dbuf: directed stimulus, transaction-level model checked
// every cycle, plus literal expectations on captured words.
`timescale 1ns/1ps
module tb_rds_msg_dbuf;
  import rds_msg_dbuf_pkg::*;

  localparam int DATA_W    = 8;
  localparam int MSG_BYTES = 52;
  localparam int ADDR_W    = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0, commit = 1'b0, rd_ready = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, rb_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              commit_pending, active_bank, rd_valid, msg_wrap;
  logic [DATA_W-1:0] rd_data, rb_data;
  logic [ADDR_W-1:0] rd_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rds_msg_dbuf #(.DATA_W(DATA_W), .MSG_BYTES(MSG_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_pending(commit_pending), .active_bank(active_bank),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr),
    .msg_wrap(msg_wrap), .rb_addr(rb_addr), .rb_data(rb_data)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [2][MSG_BYTES];
  int         m_addr = 0, m_wait = 2;
  bit         m_valid = 0, m_bank = 0, m_pending = 0, m_started = 0;
  bit         m_hs, m_swap;
  logic [7:0] m_data = 8'h00, m_rb = 8'h00;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < MSG_BYTES; a++) m_mem[b][a] = rds_msg_map[a];
  end

  // A word becomes visible two cycles after the previous one is accepted.
  always @(posedge clk) begin
    if (rst) begin
      m_started = 1; m_bank = 0; m_pending = 0; m_addr = 0;
      m_valid = 0; m_wait = 2; m_data = 8'h00; m_rb = 8'h00;
    end else begin
      m_hs   = m_valid && rd_ready;
      m_swap = m_hs && (m_addr == MSG_BYTES-1) && (m_pending || commit);
`ifdef RDS_SHADOW_READBACK_EN
      m_rb = (int'(rb_addr) < MSG_BYTES) ? m_mem[!m_bank][rb_addr] : 8'h00;
`else
      m_rb = 8'h00;
`endif
      if (wr_en && int'(wr_addr) < MSG_BYTES && !m_pending && !commit)
        m_mem[!m_bank][wr_addr] = wr_data;
      if (m_hs) begin
        m_valid = 0; m_wait = 2; m_addr = (m_addr + 1) % MSG_BYTES;
      end else if (!m_valid) begin
        m_wait--;
        if (m_wait == 0) begin m_valid = 1; m_data = m_mem[m_bank][m_addr]; end
      end
      if (m_swap) begin m_bank = !m_bank; m_pending = 0; end
      else if (commit) m_pending = 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_started) begin
      check("rd_valid", rd_valid, m_valid);
      if (m_valid) begin
        check("rd_addr", rd_addr, m_addr);
        check("rd_data", rd_data, m_data);
      end
      check("commit_pending", commit_pending, m_pending);
      check("active_bank", active_bank, m_bank);
      check("msg_wrap", msg_wrap, (!rst && m_valid && rd_ready && m_addr == MSG_BYTES-1));
      check("rb_data", rb_data, m_rb);
    end
  end

  // Capture accepted words.
  int         cap_addr[$];
  logic [7:0] cap_data[$];
  always @(negedge clk) begin
    if (m_started && !rst && rd_valid && rd_ready) begin
      cap_addr.push_back(int'(rd_addr));
      cap_data.push_back(rd_data);
    end
  end

  task automatic wait_caps(input int n, input int limit, input string name);
    int cyc = 0;
    while (cap_addr.size() < n && cyc < limit) begin
      @(posedge clk); #1; cyc++;
    end
    check(name, int'(cap_addr.size() >= n), 1);
  endtask

  task automatic wait_addr(input int a, input string name);
    int cyc = 0;
    bit hit = 0;
    while (!hit && cyc < 400) begin
      @(negedge clk); cyc++;
      if (rd_valid && int'(rd_addr) == a) hit = 1;
    end
    check(name, int'(hit), 1);
  endtask

  initial begin
    int lat, base, bad;
    bit seen;
    rd_ready = 1'b1;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_active_bank", active_bank, 0);
    check("rst_commit_pending", commit_pending, 0);
    check("rst_msg_wrap", msg_wrap, 0);
    check("rst_rb_data", rb_data, 0);
    rst = 1'b0;

    // First word latency.
    lat = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rd_valid) seen = 1; else lat++;
    end
    check("first_valid_latency", lat, 2);

    wait_caps(53, 400, "first_message");
    check("word0_addr", cap_addr[0], 0);
    check("word0_data", cap_data[0], 8'h48);
    check("word6_data", cap_data[6], 8'h52);
    check("word51_addr", cap_addr[51], 51);
    check("word51_data", cap_data[51], 8'h42);
    check("after_wrap_addr", cap_addr[52], 0);

    // Uncommitted shadow write does not disturb the stream.
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'hA5;
    @(posedge clk); #1;
    wr_en = 1'b0;
    base = cap_addr.size();
    wait_caps(base + 3*MSG_BYTES, 3*MSG_BYTES*3 + 50, "three_messages");
    bad = 0;
    for (int i = base; i < cap_addr.size(); i++)
      if (cap_addr[i] == 3 && cap_data[i] != 8'h4C) bad++;
    check("addr3_unchanged", bad, 0);
    check("bank_still_0", active_bank, 0);

    // Fill shadow, commit mid-message, then a second commit plus a dropped write.
    for (int i = 0; i < MSG_BYTES; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 8'(8'h80 + i);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    wait_addr(10, "reach_addr10");
    @(posedge clk); #1;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    check("pending_after_commit", commit_pending, 1);
    commit = 1'b1; wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h11;
    @(posedge clk); #1;
    commit = 1'b0; wr_en = 1'b0;
    check("pending_still_set", commit_pending, 1);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (active_bank) seen = 1;
    end
    check("swap_seen", int'(seen), 1);
    base = cap_addr.size();
    check("wrap_word_before_swap", cap_addr[base-1], 51);
    wait_caps(base + 6, 100, "new_bank_words");
    check("newbank_addr0", cap_addr[base], 0);
    check("newbank_word0", cap_data[base], 8'h80);
    check("newbank_word1", cap_data[base+1], 8'h81);
    check("newbank_word5", cap_data[base+5], 8'h85);

    // Random backpressure over 200 words.
    base = cap_addr.size();
    for (int i = 0; i < 6000 && cap_addr.size() < base + 200; i++) begin
      @(posedge clk); #1;
      rd_ready = 1'($urandom_range(0, 1));
    end
    rd_ready = 1'b1;
    check("random_200_words", int'(cap_addr.size() >= base + 200), 1);
    bad = 0;
    for (int i = base + 1; i < cap_addr.size(); i++)
      if (cap_addr[i] != (cap_addr[i-1] + 1) % MSG_BYTES) bad++;
    check("no_skip_or_dup", bad, 0);

    // Reset mid-stream with a commit pending.
    wait_addr(12, "reach_addr12");
    @(posedge clk); #1;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    wait_addr(19, "reach_addr19");
    @(posedge clk); #1;
    rd_ready = 1'b0;
    wait_addr(20, "reach_addr20");
    @(posedge clk); #1;
    check("pending_before_rst", commit_pending, 1);
    check("bank1_before_rst", active_bank, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_bank", active_bank, 0);
    check("rst_mid_pending", commit_pending, 0);
    check("rst_mid_valid", rd_valid, 0);
    rd_ready = 1'b1;
    base = cap_addr.size();
    wait_caps(base + 2, 50, "restart_words");
    check("restart_addr0", cap_addr[base], 0);
    check("restart_data0", cap_data[base], 8'h48);

    // Shadow readback (shadow is now bank 1 = 0x80+i).
    @(posedge clk); #1;
    rb_addr = 6'd3;
    @(posedge clk); #1;
`ifdef RDS_SHADOW_READBACK_EN
    check("rb_addr3", rb_data, 8'h83);
`else
    check("rb_addr3", rb_data, 8'h00);
`endif
    rb_addr = 6'd60;
    @(posedge clk); #1;
    check("rb_out_of_range", rb_data, 8'h00);
    repeat (4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
